// File: rtl/clockdiv_pkg.sv
// Shared constants and helpers for the clock divider.
// Phase-width and counter-width functions, plus named division ratios.
package clockdiv_pkg;

    // Ratios for a 50 MHz clkin
    localparam int DIV_2KHZ = 25000;
    localparam int DIV_2HZ  = 25000000;

    typedef struct packed {
        int low;
        int high;
    } phase_t;

    // Low phase takes the ceiling half, so odd ratios run low one cycle longer
    function automatic phase_t phases(input int div);
        phase_t p;
        p.low  = div - div / 2;
        p.high = div / 2;
        return p;
    endfunction

    function automatic int cnt_width(input int div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/clockdiv_if.sv
// Output bundle of the clock divider.
// clkout: divided clock; tick: one-cycle strobe at each clkout rise.
interface clockdiv_if;
    logic clkout;
    logic tick;

    modport master (output clkout, output tick);
    modport slave  (input  clkout, input  tick);
endinterface

// File: rtl/clockdiv_counter.sv
// Wrapping counter 0..MAX-1 for the clock divider.
// Ports: clkin, rst_n (async, active low), cnt, wrap (cnt == MAX-1).
module clockdiv_counter #(
    parameter int MAX   = 4,
    parameter int WIDTH = 2
) (
    input  logic             clkin,
    input  logic             rst_n,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap
);

    assign wrap = (cnt == WIDTH'(MAX - 1));

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/clockdiv.sv
// Integer clock divider: clkout period = DIV clkin cycles, registered output.
// Ports: clkin, rst_n (async, active low), out (clockdiv_if.master: clkout, tick).
// Macro CLOCKDIV_TICK_EN enables the tick strobe; otherwise tick is tied to 0.
module clockdiv
    import clockdiv_pkg::*;
#(
    parameter int DIV = DIV_2KHZ
) (
    input  logic         clkin,
    input  logic         rst_n,
    clockdiv_if.master   out
);

    localparam phase_t PH  = phases(DIV);
    localparam int     LOW = PH.low;
    localparam int     W   = cnt_width(DIV);

    if (DIV < 2) begin : g_bad_div
        $error("clockdiv: DIV must be at least 2");
    end

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_nxt;
    logic         wrap;
    logic         clk_q;

    clockdiv_counter #(
        .MAX   (DIV),
        .WIDTH (W)
    ) u_cnt (
        .clkin (clkin),
        .rst_n (rst_n),
        .cnt   (cnt),
        .wrap  (wrap)
    );

    // Compare against the next count so clkout lines up with cnt itself:
    // clkout is high exactly while cnt is in LOW..DIV-1.
    assign cnt_nxt = wrap ? '0 : cnt + 1'b1;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            clk_q <= 1'b0;
        end else begin
            clk_q <= (cnt_nxt >= W'(LOW));
        end
    end

    assign out.clkout = clk_q;

`ifdef CLOCKDIV_TICK_EN
    logic tick_q;

    // High during the first high cycle of clkout
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= (cnt_nxt == W'(LOW));
        end
    end

    assign out.tick = tick_q;
`else
    assign out.tick = 1'b0;
`endif

endmodule

// File: tb/tb_clockdiv.sv
// Testbench for clockdiv: five instances (DIV 4, 5, 2, 6, 25000) on a 50 MHz clock.
// Checks every cycle against an edge-count reference model, plus phase run lengths.
module tb_clockdiv;

    localparam int N = 5;
    localparam int DV [N] = '{4, 5, 2, 6, 25000};

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #10 clk = ~clk;

    clockdiv_if if0 ();
    clockdiv_if if1 ();
    clockdiv_if if2 ();
    clockdiv_if if3 ();
    clockdiv_if if4 ();

    clockdiv #(.DIV(4))     u0 (.clkin(clk), .rst_n(rst_n), .out(if0));
    clockdiv #(.DIV(5))     u1 (.clkin(clk), .rst_n(rst_n), .out(if1));
    clockdiv #(.DIV(2))     u2 (.clkin(clk), .rst_n(rst_n), .out(if2));
    clockdiv #(.DIV(6))     u3 (.clkin(clk), .rst_n(rst_n), .out(if3));
    clockdiv #(.DIV(25000)) u4 (.clkin(clk), .rst_n(rst_n), .out(if4));

    logic [N-1:0] obs_clk;
    logic [N-1:0] obs_tick;

    assign obs_clk  = {if4.clkout, if3.clkout, if2.clkout, if1.clkout, if0.clkout};
    assign obs_tick = {if4.tick, if3.tick, if2.tick, if1.tick, if0.tick};

    int n_cmp = 0;
    int n_bad = 0;
    int k = 0;

    logic prev [N];
    bit   seen [N];
    int   run  [N];

    function automatic int low_of(input int div);
        return (div + 1) / 2;
    endfunction

    function automatic logic exp_clk(input int div, input int edges);
        return ((edges % div) >= low_of(div)) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic exp_tick(input int div, input int edges);
`ifdef CLOCKDIV_TICK_EN
        return ((edges % div) == low_of(div)) ? 1'b1 : 1'b0;
`else
        return (div > 0 && edges < 0) ? 1'b1 : 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input int div, input int o, input int e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s div=%0d k=%0d observed=%0d expected=%0d",
                   tag, div, k, o, e);
        end
    endtask

    task automatic clear_runs();
        for (int i = 0; i < N; i++) begin
            prev[i] = 1'b0;
            seen[i] = 1'b0;
            run[i]  = 0;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            chk("clkout", DV[i], int'(obs_clk[i]), int'(exp_clk(DV[i], k)));
            chk("tick", DV[i], int'(obs_tick[i]), int'(exp_tick(DV[i], k)));
            if (obs_clk[i] !== prev[i]) begin
                if (seen[i]) begin
                    if (prev[i])
                        chk("high_run", DV[i], run[i], DV[i] / 2);
                    else
                        chk("low_run", DV[i], run[i], DV[i] - DV[i] / 2);
                end
                if (obs_clk[i] === 1'b1)
                    seen[i] = 1'b1;
                run[i] = 1;
            end else begin
                run[i]++;
            end
            prev[i] = obs_clk[i];
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n)
            k++;
        @(negedge clk);
        check_all();
    endtask

    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++)
            cycle();
    endtask

    initial begin
        int hold;
        int guard;

        clear_runs();
        rst_n = 1'b0;
        k = 0;
        run_cycles(3);

        #2 rst_n = 1'b1;
        run_cycles(100 + int'($urandom_range(0, 60)));

        for (int p = 0; p < 3; p++) begin
            guard = 0;
            while (exp_clk(4, k) !== 1'b1 && guard < 8) begin
                cycle();
                guard++;
            end
            chk("d4_high_before_rst", 4, int'(obs_clk[0]), 1);
            #3 rst_n = 1'b0;
            #1;
            k = 0;
            for (int i = 0; i < N; i++) begin
                chk("async_rst_clkout", DV[i], int'(obs_clk[i]), 0);
                chk("async_rst_tick", DV[i], int'(obs_tick[i]), 0);
            end
            clear_runs();
            hold = int'($urandom_range(0, 3));
            if (hold > 0) begin
                run_cycles(hold);
                #2 rst_n = 1'b1;
            end else begin
                #2 rst_n = 1'b1;
            end
            run_cycles(20 + int'($urandom_range(0, 40)));
        end

        run_cycles(50200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clockdiv.md
CLOCKDIV -- requirements
Module: clockdiv

Interface
REQ-001 The parameter DIV SHALL default to 25000 and set the division ratio: one clkout period equals DIV clkin cycles.
REQ-002 Port clkin SHALL be an input, 1 bit wide, and SHALL be the sole clock; all logic is on its rising edge.
REQ-003 Port rst_n SHALL be an input, 1 bit wide, and SHALL be the asynchronous, active-low reset.
REQ-004 Port clkout SHALL be an output, 1 bit wide, carrying the divided clock, driven from a register.
REQ-005 Port tick SHALL be an output, 1 bit wide, carrying a one-clkin-cycle strobe marking each clkout rising edge (see Configuration).

Function
REQ-006 DIV SHALL be an integer of at least 2; DIV < 2 SHALL be rejected at elaboration with an error.
REQ-007 An internal counter cnt SHALL be $clog2(DIV) bits wide and SHALL count 0..DIV-1, incrementing by 1 per clkin rising edge and wrapping from DIV-1 to 0.
REQ-008 Phase widths: LOW = DIV - DIV/2 (ceiling half), HIGH = DIV/2 (integer floor).
REQ-009 clkout SHALL be 0 while cnt is in 0..LOW-1 and 1 while cnt is in LOW..DIV-1, and it SHALL be registered so it is glitch-free.
REQ-010 Even DIV SHALL give a 50% duty cycle; odd DIV SHALL give a low phase one clkin cycle longer than the high phase.
REQ-011 The first clkout rising edge after reset release SHALL occur on the LOW-th clkin rising edge after release.
REQ-012 The clkout period SHALL be exactly DIV clkin cycles, with no drift or skipped cycles across counter wrap.
REQ-013 DIV=2 SHALL give clkout toggling on every clkin rising edge (clkin/2).
REQ-014 No combinational path SHALL exist from clkin or rst_n to clkout; clkin SHALL NOT be gated.

Reset
REQ-015 Asserting rst_n=0 SHALL immediately, without waiting for a clock edge, force cnt=0, clkout=0 and tick=0.
REQ-016 Reset asserted mid-period SHALL abandon the current period; after release the sequence SHALL restart as in REQ-011.
REQ-017 Reset release SHALL be assumed synchronized upstream; the block adds no synchronizer.

Configuration
REQ-018 Macro CLOCKDIV_TICK_EN, when defined, SHALL make tick=1 for exactly one clkin cycle, in the cycle in which clkout is first 1 after each 0-to-1 transition; this gives one pulse per DIV cycles.
REQ-019 Without CLOCKDIV_TICK_EN, the tick port SHALL remain present but be tied to constant 0, and no tick logic SHALL be synthesized.

Structure
REQ-020 A shared package clockdiv_pkg SHALL hold the helper function computing LOW and HIGH from DIV, the counter-width function, and the named ratio constants DIV_2KHZ=25000 and DIV_2HZ=25000000 (for a 50 MHz clkin).
REQ-021 The wrapping counter SHALL be one sub-module, clockdiv_counter (parameters MAX, width), exposing cnt and a wrap flag; clockdiv adds the phase compare, the output register and the tick logic.

Verification
REQ-022 The bench SHALL cover: DIV=4, reset released -> clkout pattern 0,0,1,1 repeating; first rise on the 2nd clkin edge; period 4.
REQ-023 The bench SHALL cover: DIV=5 -> low for 3 cycles, high for 2, period 5 across at least 10 periods.
REQ-024 The bench SHALL cover: DIV=2 -> clkout toggles on every clkin edge; DIV=1 -> elaboration error.
REQ-025 The bench SHALL cover: DIV=25000 with a 50 MHz clkin -> clkout at 2 kHz, high for 12500 cycles and low for 12500 cycles.
REQ-026 The bench SHALL cover: rst_n pulsed low between clock edges while clkout=1 -> clkout=0 at once, with no clock edge needed; after release the first rise follows after LOW edges.
REQ-027 The bench SHALL cover: CLOCKDIV_TICK_EN defined with DIV=6 -> exactly one tick per 6 cycles, aligned with the first high cycle of clkout; macro undefined -> tick constant 0.
